// File: rtl/audio_fft_framer.sv
// audio_fft_framer: collects signed PCM samples into whole FFT frames in a
// two-frame circular buffer and streams committed frames out over AXI-Stream.
module audio_fft_framer #(
    parameter int unsigned FRAME_LEN    = 512,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned SAMPLE_WIDTH = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    enable_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    output logic [31:0]             m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    overflow_out,
    output logic [15:0]             drop_count_out,
    output logic [15:0]             frames_out
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned FW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] { EMPTY, FETCH, HOLD } rd_state_t;

    logic [SAMPLE_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           commit_ptr;
    logic [PW-1:0]           rd_ptr;
    rd_state_t               state;
    logic                    skid_valid;
    logic [SAMPLE_WIDTH-1:0] skid_data;
    logic                    skid_last;

    logic write_c;
    logic drop_c;
    logic full_c;
    logic frame_end_c;
    logic handshake_c;
    logic out_free_c;
    logic skid_move_c;
    logic fetch_c;

    // Full is judged against the pre-read rd_ptr, so it errs by at most one entry.
    assign full_c      = (wr_ptr - rd_ptr) >= PW'(DEPTH);
    assign write_c     = sample_valid_in && enable_in && !full_c;
    assign drop_c      = sample_valid_in && enable_in && full_c;
    assign frame_end_c = (wr_ptr - commit_ptr) == PW'(FRAME_LEN - 1);

    // The skid register holds the beat after the one in the output register,
    // which is what allows one beat per cycle despite the registered RAM read.
    assign m_axis_tvalid = (state == HOLD);
    assign handshake_c   = m_axis_tvalid && m_axis_tready;
    assign out_free_c    = !m_axis_tvalid || m_axis_tready;
    assign skid_move_c   = skid_valid && out_free_c;
    assign fetch_c       = (rd_ptr != commit_ptr) && (!skid_valid || skid_move_c);

    // Sample storage write port.
    always_ff @(posedge clk_in) begin
        if (write_c && !rst_in) begin
            mem[wr_ptr[AW-1:0]] <= sample_in;
        end
    end

    // Write pointer, frame commit, and overflow bookkeeping.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            overflow_out   <= 1'b0;
            drop_count_out <= '0;
        end else begin
            overflow_out <= 1'b0;
            if (!enable_in) begin
                wr_ptr <= commit_ptr;
            end else if (write_c) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (frame_end_c) begin
                    commit_ptr <= wr_ptr + PW'(1);
                end
            end else if (drop_c) begin
                // Rewind so the torn partial frame is never committed.
                wr_ptr       <= commit_ptr;
                overflow_out <= 1'b1;
                if (drop_count_out != 16'hFFFF) begin
                    drop_count_out <= drop_count_out + 16'd1;
                end
            end
        end
    end

    // Read side: RAM prefetch into the skid, skid into the AXIS output register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= EMPTY;
            rd_ptr       <= '0;
            skid_valid   <= 1'b0;
            skid_data    <= '0;
            skid_last    <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
            frames_out   <= '0;
        end else begin
            if (fetch_c) begin
                skid_data <= mem[rd_ptr[AW-1:0]];
                skid_last <= (rd_ptr[FW-1:0] == FW'(FRAME_LEN - 1));
                rd_ptr    <= rd_ptr + PW'(1);
            end
            skid_valid <= fetch_c || (skid_valid && !skid_move_c);

            if (skid_move_c) begin
                m_axis_tdata <= {16'h0000, 16'($signed(skid_data))};
                m_axis_tlast <= skid_last;
            end

            if (handshake_c && m_axis_tlast) begin
                frames_out <= frames_out + 16'd1;
            end

            unique case (state)
                EMPTY: if (fetch_c) state <= FETCH;
                FETCH: state <= HOLD;
                HOLD: begin
                    if (handshake_c && !skid_valid) begin
                        state <= fetch_c ? FETCH : EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_fft_framer.sv
// tb_audio_fft_framer: randomized scenarios against a queue-based frame model.
module tb_audio_fft_framer;
    localparam int FL    = 512;
    localparam int DEPTH = 1024;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        enable_in;
    logic [15:0] sample_in;
    logic        sample_valid_in;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        overflow_out;
    logic [15:0] drop_count_out;
    logic [15:0] frames_out;

    audio_fft_framer #(.FRAME_LEN(FL), .DEPTH(DEPTH), .SAMPLE_WIDTH(16)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .overflow_out    (overflow_out),
        .drop_count_out  (drop_count_out),
        .frames_out      (frames_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: partial frame being filled, expected beats {tlast, tdata}.
    logic [32:0] exp_q[$];
    logic [15:0] partial[$];
    int          committed;
    int          m_drops;
    int          n_tests;
    int          n_fail;
    int          rdy_mode;

    // Observed stream and protocol-violation counters.
    logic [32:0] obs_q[$];
    int          n_hs;
    int          stall_err;
    int          gap_err;
    int          ovf_cnt;
    int          ovf_wide;
    logic        prev_stall;
    logic        prev_hs_mid;
    logic        prev_ovf;
    logic [32:0] prev_beat;

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_stall  = 1'b0;
            prev_hs_mid = 1'b0;
            prev_ovf    = 1'b0;
        end else begin
            if (prev_stall && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev_beat)) stall_err++;
            if (prev_hs_mid && !m_axis_tvalid) gap_err++;
            if (prev_ovf && overflow_out) ovf_wide++;
            if (overflow_out) ovf_cnt++;
            if (m_axis_tvalid && m_axis_tready) begin
                obs_q.push_back({m_axis_tlast, m_axis_tdata});
                n_hs++;
            end
            prev_stall  = m_axis_tvalid && !m_axis_tready;
            prev_beat   = {m_axis_tlast, m_axis_tdata};
            prev_hs_mid = m_axis_tvalid && m_axis_tready && !m_axis_tlast;
            prev_ovf    = overflow_out;
        end
    end

    // Consumer: 0 = stalled, 1 = always ready, 2 = random 50%.
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Buffer holds committed-but-unfetched plus partial entries; up to two
    // committed beats sit in the output stage and free their slots.
    function automatic bit model_sample(input logic [15:0] v);
        int pending;
        int held;
        int occ;
        pending = committed - n_hs;
        held    = (pending < 2) ? pending : 2;
        occ     = partial.size() + pending - held;
        if (occ >= DEPTH) begin
            partial.delete();
            if (m_drops < 65535) m_drops++;
            return 1'b1;
        end
        partial.push_back(v);
        if (partial.size() == FL) begin
            for (int k = 0; k < FL; k++) exp_q.push_back({(k == FL - 1), 16'h0000, partial[k]});
            committed += FL;
            partial.delete();
        end
        return 1'b0;
    endfunction

    task automatic send(input logic [15:0] v, output bit drop);
        drop            = model_sample(v);
        sample_in       = v;
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
    endtask

    task automatic drain(output bit ok);
        int t;
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 20000) begin
            tick();
            t++;
        end
        ok = (obs_q.size() >= exp_q.size());
        repeat (8) tick();
    endtask

    task automatic clear_model();
        exp_q.delete();
        partial.delete();
        obs_q.delete();
        committed = 0;
        n_hs      = 0;
        m_drops   = 0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) tick();
        n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
        n_tests++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); end
        n_tests++; if (m_axis_tdata !== 32'h0) begin n_fail++; $display("FAIL rst_tdata: got %h want 0", m_axis_tdata); end
        n_tests++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", overflow_out); end
        n_tests++; if (drop_count_out !== 16'h0) begin n_fail++; $display("FAIL rst_drops: got %h want 0", drop_count_out); end
        n_tests++; if (frames_out !== 16'h0) begin n_fail++; $display("FAIL rst_frames: got %h want 0", frames_out); end
        rst_in = 1'b0;
        clear_model();
    endtask

    task automatic test_single_frame();
        bit drop;
        bit ok;
        rdy_mode = 1;
        for (int i = 0; i < FL - 1; i++) begin
            send(16'(i), drop);
            repeat (31) tick();
        end
        send(16'(FL - 1), drop);
        n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL lat_cycle0: got %b want 0", m_axis_tvalid); end
        tick();
        n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL lat_cycle1: got %b want 0", m_axis_tvalid); end
        tick();
        n_tests++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL lat_cycle2: got %b want 1", m_axis_tvalid); end
        drain(ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
        n_tests++; if (frames_out !== 16'(committed / FL)) begin n_fail++; $display("FAIL single_frames: got %0d want %0d", frames_out, committed / FL); end
        n_tests++; if (drop_count_out !== 16'(m_drops)) begin n_fail++; $display("FAIL single_drops: got %0d want %0d", drop_count_out, m_drops); end
    endtask

    task automatic test_overflow();
        bit drop;
        bit ok;
        int ovf0;
        rdy_mode = 0;
        ovf0 = ovf_cnt;
        for (int i = 0; i < 1100; i++) begin
            send(16'($urandom()), drop);
            n_tests++; if (overflow_out !== drop) begin n_fail++; $display("FAIL ovf_pulse[%0d]: got %b want %b", i, overflow_out, drop); end
            tick();
            n_tests++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL ovf_width[%0d]: got %b want 0", i, overflow_out); end
            repeat (2) tick();
        end
        n_tests++; if (drop_count_out !== 16'(m_drops)) begin n_fail++; $display("FAIL ovf_drops: got %0d want %0d", drop_count_out, m_drops); end
        n_tests++; if (ovf_cnt - ovf0 !== m_drops) begin n_fail++; $display("FAIL ovf_pulses: got %0d want %0d", ovf_cnt - ovf0, m_drops); end
        n_tests++; if (ovf_wide !== 0) begin n_fail++; $display("FAIL ovf_wide: got %0d want 0", ovf_wide); end
        rdy_mode = 1;
        drain(ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < FL; i++) begin
            send(16'($urandom()), drop);
            tick();
        end
        drain(ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fresh_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fresh_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
        n_tests++; if (frames_out !== 16'(committed / FL)) begin n_fail++; $display("FAIL ovf_frames: got %0d want %0d", frames_out, committed / FL); end
    endtask

    task automatic test_random_stream();
        bit drop;
        bit ok;
        rdy_mode = 2;
        for (int i = 0; i < 4 * FL; i++) begin
            send(16'($urandom()), drop);
            repeat ($urandom_range(2, 4)) tick();
        end
        rdy_mode = 1;
        drain(ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
        n_tests++; if (stall_err !== 0) begin n_fail++; $display("FAIL rand_stall_stable: got %0d changes want 0", stall_err); end
        n_tests++; if (gap_err !== 0) begin n_fail++; $display("FAIL rand_no_gaps: got %0d gaps want 0", gap_err); end
        n_tests++; if (drop_count_out !== 16'(m_drops)) begin n_fail++; $display("FAIL rand_drops: got %0d want %0d", drop_count_out, m_drops); end
        n_tests++; if (frames_out !== 16'(committed / FL)) begin n_fail++; $display("FAIL rand_frames: got %0d want %0d", frames_out, committed / FL); end
    endtask

    task automatic test_enable_drop();
        bit drop;
        bit ok;
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send(16'($urandom()), drop);
            tick();
        end
        enable_in = 1'b0;
        partial.delete();
        sample_in       = 16'h1234;
        sample_valid_in = 1'b1;
        repeat (2) tick();
        sample_valid_in = 1'b0;
        repeat (3) tick();
        enable_in = 1'b1;
        for (int i = 0; i < FL; i++) begin
            send(16'($urandom()), drop);
            tick();
        end
        drain(ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL en_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL en_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
        n_tests++; if (drop_count_out !== 16'(m_drops)) begin n_fail++; $display("FAIL en_drops: got %0d want %0d", drop_count_out, m_drops); end
    endtask

    task automatic test_reset_mid();
        bit drop;
        bit ok;
        int base;
        int t;
        rdy_mode = 0;
        base = committed / FL;
        for (int i = 0; i < 2 * FL; i++) send(16'($urandom()), drop);
        rdy_mode = 1;
        t = 0;
        while (obs_q.size() < FL + 200 && t < 5000) begin
            tick();
            t++;
        end
        n_tests++; if (obs_q.size() < FL + 200) begin n_fail++; $display("FAIL mid_reach: got %0d beats want %0d", obs_q.size(), FL + 200); end
        n_tests++; if (frames_out !== 16'(base + 1)) begin n_fail++; $display("FAIL mid_frames_before: got %0d want %0d", frames_out, base + 1); end
        rst_in = 1'b1;
        tick();
        n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_tvalid: got %b want 0", m_axis_tvalid); end
        n_tests++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL mid_tlast: got %b want 0", m_axis_tlast); end
        n_tests++; if (m_axis_tdata !== 32'h0) begin n_fail++; $display("FAIL mid_tdata: got %h want 0", m_axis_tdata); end
        n_tests++; if (frames_out !== 16'h0) begin n_fail++; $display("FAIL mid_frames: got %0d want 0", frames_out); end
        n_tests++; if (drop_count_out !== 16'h0) begin n_fail++; $display("FAIL mid_drops: got %0d want 0", drop_count_out); end
        rst_in = 1'b0;
        clear_model();
        for (int i = 0; i < FL; i++) begin
            send(16'($urandom()), drop);
            tick();
        end
        drain(ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL post_rst_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL post_rst_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
        n_tests++; if (frames_out !== 16'h1) begin n_fail++; $display("FAIL post_rst_frames: got %0d want 1", frames_out); end
    endtask

    task automatic test_min_value();
        bit drop;
        bit ok;
        logic [15:0] v;
        rdy_mode = 1;
        for (int i = 0; i < FL; i++) begin
            v = (i == 0) ? 16'h8000 : (i == 1) ? 16'h7FFF : 16'($urandom());
            send(v, drop);
            tick();
        end
        drain(ok);
        n_tests++;
        if (obs_q.size() < 2 || obs_q[0] !== 33'h0_0000_8000) begin n_fail++; $display("FAIL min_value: got %0d beats, first %h want 000008000", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 33'h0); end
        n_tests++;
        if (obs_q.size() < 2 || obs_q[1] !== 33'h0_0000_7FFF) begin n_fail++; $display("FAIL max_value: got %0d beats want second 000007fff", obs_q.size()); end
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ext_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ext_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        rst_in          = 1'b0;
        enable_in       = 1'b1;
        sample_in       = 16'h0;
        sample_valid_in = 1'b0;
        rdy_mode        = 1;
        n_tests         = 0;
        n_fail          = 0;
        stall_err       = 0;
        gap_err         = 0;
        ovf_cnt         = 0;
        ovf_wide        = 0;
        clear_model();
        test_reset();
        test_single_frame();
        test_overflow();
        test_random_stream();
        test_enable_drop();
        test_reset_mid();
        test_min_value();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
